// File: rtl/hfc_pkg.sv
// Shared types for the hazard/forwarding controller: forward-mux encoding,
// per-stage destination shadow record and the forward-select helper.
package hfc_pkg;

  localparam int HFC_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [HFC_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } stage_info_t;

  // Select computed in ID, consumed one cycle later in EX: the EX producer
  // will then sit in MEM, the MEM producer in WB. Nearer stage wins.
  function automatic fwd_sel_t fwd_pick(input logic [HFC_REG_ADDR_W-1:0] src,
                                        input logic                      used,
                                        input stage_info_t               ex,
                                        input stage_info_t               mem);
    fwd_pick = FWD_REG;
    if (used && (src != '0)) begin
      if (ex.regwrite && (src == ex.rd))        fwd_pick = FWD_MEM;
      else if (mem.regwrite && (src == mem.rd)) fwd_pick = FWD_WB;
    end
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-side decode inputs and front-end/forward control outputs of the hazard
// controller. slave = controller side, master = pipeline side.
interface hazard_forward_ctrl_if #(
  parameter int REG_ADDR_W = hfc_pkg::HFC_REG_ADDR_W
);
  import hfc_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_muldiv;
  logic                  ex_branch_taken;

  fwd_sel_t              fwd_a_sel;
  fwd_sel_t              fwd_b_sel;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_bubble;
  logic                  flush_ifid;
  logic                  muldiv_busy;

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_muldiv, ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, pc_write, ifid_write,
           idex_bubble, flush_ifid, muldiv_busy
  );

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_muldiv, ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, pc_write, ifid_write,
           idex_bubble, flush_ifid, muldiv_busy
  );

endinterface

// File: rtl/hfc_muldiv_timer.sv
// EX-occupancy down-counter for multi-cycle mul/div; busy while non-zero.
module hfc_muldiv_timer #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_i,
  output logic busy_o
);

  // LAT-1 is the largest value ever loaded
  localparam int CNT_W = (LAT > 2) ? $clog2(LAT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
    else if (issue_i) cnt_d = CNT_W'(LAT - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX forwarding-select, load-use stall and branch-flush controller.
// Optional multi-cycle mul/div hold is built when HFC_MULDIV_EN is defined.
module hazard_forward_ctrl
  import hfc_pkg::*;
#(
  parameter int REG_ADDR_W = HFC_REG_ADDR_W,
  parameter int MULDIV_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_ctrl_if.slave bus
);

  logic [REG_ADDR_W-1:0] rs, rt;
  stage_info_t           id_info;
  stage_info_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  fwd_sel_t              fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_t              calc_a, calc_b;
  logic                  busy, flush, load_use, stall, bubble;

  assign rs = bus.id_rs;
  assign rt = bus.id_rt;

  always_comb begin
    id_info          = '0;
    id_info.rd       = bus.id_rd;
    id_info.regwrite = bus.id_regwrite;
    id_info.memread  = bus.id_memread;
  end

  // A taken branch is not acted on while mul/div owns EX.
  assign flush    = bus.ex_branch_taken && !busy;
  assign load_use = ex_q.memread && ex_q.regwrite && (ex_q.rd != '0) &&
                    ((bus.id_uses_rs && (rs == ex_q.rd)) ||
                     (bus.id_uses_rt && (rt == ex_q.rd)));
  assign stall    = load_use && !flush && !busy;
  assign bubble   = flush || stall;

  assign calc_a = fwd_pick(rs, bus.id_uses_rs, ex_q, mem_q);
  assign calc_b = fwd_pick(rt, bus.id_uses_rt, ex_q, mem_q);

  always_comb begin
    ex_d    = id_info;
    mem_d   = ex_q;
    wb_d    = mem_q;
    fwd_a_d = calc_a;
    fwd_b_d = calc_b;
    if (busy) begin
      // ID/EX frozen; the vacated MEM slot fills with a bubble
      ex_d    = ex_q;
      mem_d   = '0;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else if (bubble) begin
      ex_d    = '0;
      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

`ifdef HFC_MULDIV_EN
  logic issue;

  assign issue = bus.id_muldiv && !bubble && !busy;

  hfc_muldiv_timer #(.LAT(MULDIV_LAT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .issue_i (issue),
    .busy_o  (busy)
  );
`else
  assign busy = 1'b0;
`endif

  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.pc_write    = !stall && !busy;
  assign bus.ifid_write  = !stall && !busy;
  assign bus.idex_bubble = bubble;
  assign bus.flush_ifid  = flush;
  assign bus.muldiv_busy = busy;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl; case 6 is exercised only when
// HFC_MULDIV_EN is defined (MULDIV_LAT=4).
module tb_hazard_forward_ctrl;
  import hfc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  hazard_forward_ctrl_if #(.REG_ADDR_W(5)) bus();

  hazard_forward_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ctl = {pc_write, ifid_write, idex_bubble, flush_ifid}
  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_STALL = 4'b0010;
  localparam logic [3:0] CTL_FLUSH = 4'b1111;
  localparam logic [3:0] CTL_HOLD  = 4'b0000;

  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.flush_ifid};
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    logic [3:0] obs;
    obs = {bus.fwd_a_sel, bus.fwd_b_sel};
    n_run++;
    assert (obs === {ea, eb}) else begin
      n_fail++;
      $error("FAIL %s fwd a/b observed=%b expected=%b", tag, obs, {ea, eb});
    end
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    n_run++;
    assert (bus.muldiv_busy === exp) else begin
      n_fail++;
      $error("FAIL %s muldiv_busy observed=%b expected=%b", tag, bus.muldiv_busy, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic md = 1'b0, input logic br = 1'b0);
    bus.id_rs           = rs;
    bus.id_uses_rs      = urs;
    bus.id_rt           = rt;
    bus.id_uses_rt      = urt;
    bus.id_rd           = rd;
    bus.id_regwrite     = rw;
    bus.id_memread      = mr;
    bus.id_muldiv       = md;
    bus.ex_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_ctl("reset ctl", CTL_RUN);
    chk_fwd("reset fwd", FWD_REG, FWD_REG);
    chk_busy("reset busy", 1'b0);
    rst = 1'b0;

    // Case 1: add r3 ; add r5,r3,r4 -> EX forward
    set_id(1, 1, 2, 1, 3, 1, 0);
    tick();
    set_id(3, 1, 4, 1, 5, 1, 0);
    chk_ctl("c1 no stall", CTL_RUN);
    tick();
    chk_fwd("c1 ex fwd", FWD_MEM, FWD_REG);

    // Case 2a: producer r3, independent, consumer of r3 in rt
    set_id(1, 1, 2, 1, 3, 1, 0);
    tick();
    chk_fwd("c2 producer", FWD_REG, FWD_REG);
    set_id(1, 1, 2, 1, 8, 1, 0);
    tick();
    set_id(6, 1, 3, 1, 9, 1, 0);
    tick();
    chk_fwd("c2 wb fwd rt", FWD_REG, FWD_WB);

    // Case 2b: r3 written by both EX and MEM producers -> nearer wins
    set_id(1, 1, 2, 1, 3, 1, 0);
    tick();
    set_id(1, 1, 2, 1, 3, 1, 0);
    tick();
    set_id(3, 1, 3, 1, 10, 1, 0);
    tick();
    chk_fwd("c2 nearer wins", FWD_MEM, FWD_MEM);
    set_id(10, 1, 10, 0, 11, 1, 0);
    tick();
    chk_fwd("c2 unused rt", FWD_MEM, FWD_REG);

    // Case 3: lw r2 ; add r4,r2,r2 -> one bubble then WB forward
    set_id(1, 1, 0, 0, 2, 1, 1);
    chk_ctl("c3 lw issue", CTL_RUN);
    tick();
    set_id(2, 1, 2, 1, 4, 1, 0);
    chk_ctl("c3 load-use", CTL_STALL);
    tick();
    chk_fwd("c3 bubble sel", FWD_REG, FWD_REG);
    chk_ctl("c3 stall released", CTL_RUN);
    tick();
    chk_fwd("c3 wb fwd", FWD_WB, FWD_WB);

    // Back-to-back dependent loads: each costs one bubble
    set_id(1, 1, 0, 0, 12, 1, 1);
    tick();
    set_id(12, 1, 0, 0, 13, 1, 1);
    chk_ctl("b2b lw1 stall", CTL_STALL);
    tick();
    chk_ctl("b2b lw1 go", CTL_RUN);
    tick();
    chk_fwd("b2b lw1 fwd", FWD_WB, FWD_REG);
    set_id(13, 1, 0, 0, 14, 1, 0);
    chk_ctl("b2b lw2 stall", CTL_STALL);
    tick();
    chk_ctl("b2b lw2 go", CTL_RUN);
    tick();
    chk_fwd("b2b lw2 fwd", FWD_WB, FWD_REG);

    // Case 4: writes to r0 never forward or stall
    set_id(1, 1, 2, 1, 0, 1, 0);
    tick();
    set_id(0, 1, 0, 1, 15, 1, 0);
    chk_ctl("c4 r0 alu", CTL_RUN);
    tick();
    chk_fwd("c4 r0 alu fwd", FWD_REG, FWD_REG);
    set_id(1, 1, 0, 0, 0, 1, 1);
    tick();
    set_id(0, 1, 0, 1, 16, 1, 0);
    chk_ctl("c4 lw r0 no stall", CTL_RUN);
    tick();
    chk_fwd("c4 lw r0 fwd", FWD_REG, FWD_REG);

    // Case 5: branch taken coincident with load-use -> flush wins
    set_id(1, 1, 0, 0, 2, 1, 1);
    tick();
    set_id(2, 1, 2, 1, 4, 1, 0, 1'b0, 1'b1);
    chk_ctl("c5 flush prio", CTL_FLUSH);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    chk_fwd("c5 flushed sel", FWD_REG, FWD_REG);

    // Reset asserted mid load-use stall clears everything at once
    set_id(1, 1, 0, 0, 2, 1, 1);
    tick();
    set_id(2, 1, 2, 1, 4, 1, 0);
    chk_ctl("rst pre stall", CTL_STALL);
    rst = 1'b1;
    #1;
    chk_ctl("rst mid stall", CTL_RUN);
    tick();
    rst = 1'b0;
    tick();
    chk_fwd("rst empty pipe", FWD_REG, FWD_REG);

`ifdef HFC_MULDIV_EN
    // Case 6: mul occupies EX for 4 cycles, 3 of them busy
    set_id(1, 1, 2, 1, 20, 1, 0, 1'b1);
    chk_busy("c6 issue", 1'b0);
    tick();
    set_id(20, 1, 5, 1, 21, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk_busy($sformatf("c6 busy%0d", i), 1'b1);
      chk_ctl($sformatf("c6 hold%0d", i), CTL_HOLD);
      if (i == 1) begin
        bus.ex_branch_taken = 1'b1;
        #1;
        chk_ctl("c6 branch ignored", CTL_HOLD);
        bus.ex_branch_taken = 1'b0;
      end
      tick();
    end
    chk_busy("c6 done", 1'b0);
    chk_ctl("c6 released", CTL_RUN);
    tick();
    chk_fwd("c6 mul fwd", FWD_MEM, FWD_REG);

    // Reset on the second busy cycle
    set_id(1, 1, 2, 1, 22, 1, 0, 1'b1);
    tick();
    set_id(22, 1, 0, 0, 23, 1, 0);
    tick();
    chk_busy("c6 second busy", 1'b1);
    rst = 1'b1;
    #1;
    chk_busy("c6 rst busy", 1'b0);
    chk_ctl("c6 rst ctl", CTL_RUN);
    chk_fwd("c6 rst fwd", FWD_REG, FWD_REG);
    tick();
    rst = 1'b0;
`else
    // Feature compiled out: id_muldiv has no effect
    set_id(1, 1, 2, 1, 20, 1, 0, 1'b1);
    tick();
    set_id(20, 1, 0, 0, 21, 1, 0);
    chk_busy("nomd busy", 1'b0);
    chk_ctl("nomd ctl", CTL_RUN);
    tick();
    chk_fwd("nomd fwd", FWD_MEM, FWD_REG);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
